matrix_3x3_gen: RTL and testbench
=================================

Name: matrix_3x3_gen

Overview:
- Producer of the 3x3 pixel window consumed by the neighbourhood filters (Gaussian, Sobel, median) in the 8-bit grey video path.
- Takes a raster pixel stream with vs/hs/de, buffers two previous lines in block RAM, and emits nine taps plus aligned sync.
- Sits between the greyscale converter and the filter stage, on the same video_clk domain.

Parameters:
- IMG_WIDTH, 640, active pixels per line; sets line-buffer depth.
- DATA_W, 8, pixel width.
- COL_W, 11, column counter width; requires 2^COL_W > IMG_WIDTH.

Ports:
- video_clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- video_vs  in  1  frame sync, active-high.
- video_hs  in  1  line sync.
- video_de  in  1  pixel valid.
- video_data  in  DATA_W  pixel.
- matrix_vs / matrix_hs / matrix_de  out  1 each  sync delayed by 2 cycles.
- matrix11..matrix13  out  DATA_W each  row r-2, columns c-2, c-1, c.
- matrix21..matrix23  out  DATA_W each  row r-1, same columns.
- matrix31..matrix33  out  DATA_W each  row r, same columns; matrix33 is the newest pixel.

Behaviour:
- Reset is synchronous on rst=1. All outputs, shift registers, col_cnt and row_cnt go to 0. RAM contents are not cleared; row_cnt masking hides stale data.
- Mid-frame reset: the next line is treated as row 0.
- col_cnt counts from 0 while video_de=1 and clears when video_de=0.
- row_cnt increments on the falling edge of video_de and saturates at 2. It clears on the rising edge of video_vs.
- Two line buffers (lb0 holds row r-1, lb1 holds row r-2) are addressed by col_cnt. Both are read-first, with 1-cycle read latency.
- On each de cycle: video_data is written to lb0[col]; the old lb0[col] is written to lb1[col].
- Stage 1 (t+1): register video_data, lb0 output and lb1 output, together with delayed de.
- Stage 2 (t+2): the three column shift registers shift when delayed de=1, and all taps become valid.
- Shift registers clear while delayed de=0. The first two pixels of each line therefore see c-1/c-2 taps = 0.
- Missing rows read as 0:
  - row_cnt=0 forces row r-1 and r-2 taps to 0.
  - row_cnt=1 forces row r-2 taps to 0.
- Fixed latency of 2 cycles for data and for vs/hs/de. No backpressure; the block runs free every cycle.
- Pixels with col_cnt >= IMG_WIDTH: writes are suppressed and RAM taps read 0. col_cnt saturates at IMG_WIDTH.
- de asserted during vs=1: processed normally, and row_cnt still clears on the vs rising edge.

Optional Feature:
- Macro: MATRIX_REPLICATE_EN.
- Defined: borders replicate instead of zero-fill.
  - row_cnt=0: rows r-1 and r-2 take row r values.
  - row_cnt=1: row r-2 takes row r-1 values.
  - col 0: c-1 and c-2 taps equal c.
  - col 1: c-2 equals c-1.
- Undefined: zero-fill as above.

Decomposition:
- Shared package holds DATA_W, the latency constant MATRIX_LAT=2, and the row-state encoding (ROW0, ROW1, ROWN).
- One sub-module, line_buffer: single-clock, read-first, simple dual-port RAM of depth IMG_WIDTH and width DATA_W. Instantiated twice.

Test Plan:
- Reset: assert rst for 3 cycles while streaming pixels -> all outputs 0 during reset and on the first post-reset cycle. row_cnt=0 afterwards.
- Latency: IMG_WIDTH=8, ramp frame with pixel = 16*row + col; vs/hs/de pulses -> matrix_* sync equals input delayed exactly 2 cycles. Row 2, col 3 window gives:
  - matrix11..13 = 1,2,3
  - matrix21..23 = 17,18,19
  - matrix31..33 = 33,34,35
- Top/left border (zero-fill): row 0, col 0, pixel 0x55 -> matrix33=0x55, all other taps 0. Row 1, col 1 -> matrix1x=0, matrix21=0, matrix31=0.
- Border with MATRIX_REPLICATE_EN: row 0, col 0, pixel 0x55 -> all nine taps 0x55.
- Frame restart: vs pulse after 3 lines, then new frame of all-0xAA pixels -> row 0 of the new frame has matrix1x and matrix2x = 0 (old data masked).
- Overlong line: 10 pixels with IMG_WIDTH=8 -> pixels 8-9 produce 0 on RAM taps. The next line's col 0..7 reads match the first 8 pixels.

Source files
------------

// File: rtl/matrix_3x3_gen_pkg.sv
// Shared constants and types for the 3x3 window generator.
// Pixel width, pipeline latency and the row-availability state used by masking.
package matrix_3x3_gen_pkg;

    localparam int DATA_W     = 8;
    localparam int MATRIX_LAT = 2;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROWN = 2'd2
    } row_state_e;

    // Row history only matters up to two lines back, so the state saturates.
    function automatic row_state_e row_advance(input row_state_e s);
        case (s)
            ROW0:    return ROW1;
            default: return ROWN;
        endcase
    endfunction

endpackage

// File: rtl/matrix_3x3_gen_if.sv
// Raster pixel input and 3x3 window output bundle for matrix_3x3_gen.
// master drives the video stream, slave is the window generator.
interface matrix_3x3_gen_if;
    import matrix_3x3_gen_pkg::*;

    logic              video_vs;
    logic              video_hs;
    logic              video_de;
    logic [DATA_W-1:0] video_data;

    logic              matrix_vs;
    logic              matrix_hs;
    logic              matrix_de;
    logic [DATA_W-1:0] matrix11, matrix12, matrix13;
    logic [DATA_W-1:0] matrix21, matrix22, matrix23;
    logic [DATA_W-1:0] matrix31, matrix32, matrix33;

    modport master (
        output video_vs, video_hs, video_de, video_data,
        input  matrix_vs, matrix_hs, matrix_de,
        input  matrix11, matrix12, matrix13,
        input  matrix21, matrix22, matrix23,
        input  matrix31, matrix32, matrix33
    );

    modport slave (
        input  video_vs, video_hs, video_de, video_data,
        output matrix_vs, matrix_hs, matrix_de,
        output matrix11, matrix12, matrix13,
        output matrix21, matrix22, matrix23,
        output matrix31, matrix32, matrix33
    );

endinterface

// File: rtl/matrix_3x3_gen_line_buffer.sv
// Single-clock simple dual-port line RAM, read-first, one cycle read latency.
// No reset on contents or read register; consumers mask stale data.
module matrix_3x3_gen_line_buffer
    import matrix_3x3_gen_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood window generator: two line buffers plus column shift registers.
// Build option MATRIX_REPLICATE_EN replicates border pixels instead of zero-filling.
module matrix_3x3_gen
    import matrix_3x3_gen_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 11
) (
    input  logic video_clk,
    input  logic rst,
    matrix_3x3_gen_if.slave bus
);

    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef logic [DATA_W-1:0] pix_t;

    logic [COL_W-1:0]  r_col_cnt;
    row_state_e        r_row_cnt;
    logic              w_oob;
    logic [ADDR_W-1:0] w_addr;
    logic              w_de_fall;
    logic              w_vs_rise;
    logic              w_lb0_we;
    logic              w_lb1_we;
    pix_t              w_lb0_q;
    pix_t              w_lb1_q;

    logic [2:0]        r_sync_p [MATRIX_LAT];
    pix_t              r_pix_p1;
    row_state_e        r_row_p1;
    logic              r_oob_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic              w_de_p1;
`ifdef MATRIX_REPLICATE_EN
    logic              r_col0_p1;
`endif

    pix_t              w_ram0;
    pix_t              w_ram1;
    pix_t              w_tap [3];
    pix_t              r_win_p2 [3][3];

    assign w_oob     = (r_col_cnt >= COL_W'(IMG_WIDTH));
    assign w_addr    = w_oob ? '0 : r_col_cnt[ADDR_W-1:0];
    assign w_de_p1   = r_sync_p[0][0];
    assign w_de_fall = w_de_p1 & ~bus.video_de;
    assign w_vs_rise = bus.video_vs & ~r_sync_p[0][2];

    always_ff @(posedge video_clk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= ROW0;
        end else begin
            if (!bus.video_de) begin
                r_col_cnt <= '0;
            end else if (!w_oob) begin
                r_col_cnt <= r_col_cnt + COL_W'(1);
            end
            if (w_vs_rise) begin
                r_row_cnt <= ROW0;
            end else if (w_de_fall) begin
                r_row_cnt <= row_advance(r_row_cnt);
            end
        end
    end

    // lb1 receives the old lb0 word one cycle late, once lb0's read data is out.
    assign w_lb0_we = bus.video_de & ~w_oob;
    assign w_lb1_we = w_de_p1 & ~r_oob_p1;

    matrix_3x3_gen_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lb0 (
        .clk     (video_clk),
        .i_we    (w_lb0_we),
        .i_waddr (w_addr),
        .i_wdata (bus.video_data),
        .i_raddr (w_addr),
        .o_rdata (w_lb0_q)
    );

    matrix_3x3_gen_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .WIDTH  (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lb1 (
        .clk     (video_clk),
        .i_we    (w_lb1_we),
        .i_waddr (r_addr_p1),
        .i_wdata (w_lb0_q),
        .i_raddr (w_addr),
        .o_rdata (w_lb1_q)
    );

    // Stage 1: input pixel, row state and sync aligned with line-buffer read data
    always_ff @(posedge video_clk) begin
        if (rst) begin
            for (int i = 0; i < MATRIX_LAT; i++) begin
                r_sync_p[i] <= '0;
            end
            r_pix_p1  <= '0;
            r_row_p1  <= ROW0;
            r_oob_p1  <= 1'b0;
            r_addr_p1 <= '0;
`ifdef MATRIX_REPLICATE_EN
            r_col0_p1 <= 1'b0;
`endif
        end else begin
            r_sync_p[0] <= {bus.video_vs, bus.video_hs, bus.video_de};
            for (int i = 1; i < MATRIX_LAT; i++) begin
                r_sync_p[i] <= r_sync_p[i-1];
            end
            r_pix_p1  <= bus.video_data;
            r_row_p1  <= r_row_cnt;
            r_oob_p1  <= w_oob;
            r_addr_p1 <= w_addr;
`ifdef MATRIX_REPLICATE_EN
            r_col0_p1 <= (r_col_cnt == '0);
`endif
        end
    end

    always_comb begin
        w_ram0   = r_oob_p1 ? '0 : w_lb0_q;
        w_ram1   = r_oob_p1 ? '0 : w_lb1_q;
        w_tap[2] = r_pix_p1;
`ifdef MATRIX_REPLICATE_EN
        w_tap[1] = (r_row_p1 == ROW0) ? r_pix_p1 : w_ram0;
        w_tap[0] = (r_row_p1 == ROWN) ? w_ram1 : w_tap[1];
`else
        w_tap[1] = (r_row_p1 == ROW0) ? '0 : w_ram0;
        w_tap[0] = (r_row_p1 == ROWN) ? w_ram1 : '0;
`endif
    end

    // Stage 2: column shift registers, index [row][col], col 2 newest
    always_ff @(posedge video_clk) begin
        if (rst || !w_de_p1) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win_p2[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_win_p2[r][0] <= r_win_p2[r][1];
                r_win_p2[r][1] <= r_win_p2[r][2];
                r_win_p2[r][2] <= w_tap[r];
`ifdef MATRIX_REPLICATE_EN
                if (r_col0_p1) begin
                    r_win_p2[r][0] <= w_tap[r];
                    r_win_p2[r][1] <= w_tap[r];
                end
`endif
            end
        end
    end

    assign bus.matrix_vs = r_sync_p[MATRIX_LAT-1][2];
    assign bus.matrix_hs = r_sync_p[MATRIX_LAT-1][1];
    assign bus.matrix_de = r_sync_p[MATRIX_LAT-1][0];

    assign bus.matrix11 = r_win_p2[0][0];
    assign bus.matrix12 = r_win_p2[0][1];
    assign bus.matrix13 = r_win_p2[0][2];
    assign bus.matrix21 = r_win_p2[1][0];
    assign bus.matrix22 = r_win_p2[1][1];
    assign bus.matrix23 = r_win_p2[1][2];
    assign bus.matrix31 = r_win_p2[2][0];
    assign bus.matrix32 = r_win_p2[2][1];
    assign bus.matrix33 = r_win_p2[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with IMG_WIDTH=8: windows snapshotted every
// cycle, sync checked against the stimulus delayed two cycles.
module tb_matrix_3x3_gen;

    localparam int MAXC = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    bit   chk_sync;

    logic [71:0] snap  [MAXC];
    logic [2:0]  ssync [MAXC];
    logic [2:0]  hist  [MAXC];

    int t0, t1, t2, ta, tb, tc, td, te;

    matrix_3x3_gen_if bus ();

    matrix_3x3_gen #(
        .IMG_WIDTH (8),
        .COL_W     (11)
    ) dut (
        .video_clk (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input logic r, input logic vs, input logic hs,
                        input logic de, input logic [7:0] d);
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL tick_budget cycles=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        snap[cyc]  = {bus.matrix11, bus.matrix12, bus.matrix13,
                      bus.matrix21, bus.matrix22, bus.matrix23,
                      bus.matrix31, bus.matrix32, bus.matrix33};
        ssync[cyc] = {bus.matrix_vs, bus.matrix_hs, bus.matrix_de};
        if (chk_sync && cyc >= 2) begin
            checks++;
            assert (ssync[cyc] === hist[cyc-2]) else begin
                errors++;
                $error("FAIL sync_delay cyc=%0d observed=%b expected=%b",
                       cyc, ssync[cyc], hist[cyc-2]);
            end
        end
        hist[cyc]      = {vs, hs, de};
        rst            = r;
        bus.video_vs   = vs;
        bus.video_hs   = hs;
        bus.video_de   = de;
        bus.video_data = d;
        cyc++;
    endtask

    task automatic vs_pulse();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input logic [7:0] base, input logic [7:0] inc,
                             input int n, input logic [7:0] d0, output int tfirst);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tfirst = cyc;
        for (int c = 0; c < n; c++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, (c == 0) ? d0 : (base + inc * 8'(c)));
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_win(input string tag, input int idx, input logic [71:0] exp);
        checks++;
        assert (snap[idx] === exp) else begin
            errors++;
            $error("FAIL %s idx=%0d observed=%h expected=%h", tag, idx, snap[idx], exp);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        chk_sync       = 1'b0;
        rst            = 1'b1;
        bus.video_vs   = 1'b0;
        bus.video_hs   = 1'b0;
        bus.video_de   = 1'b0;
        bus.video_data = 8'h00;

        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk_win("init_reset_taps", i, 72'h0);
            checks++;
            assert (ssync[i] === 3'b000) else begin
                errors++;
                $error("FAIL init_reset_sync idx=%0d observed=%b expected=000", i, ssync[i]);
            end
        end
        chk_sync = 1'b1;

        // Ramp frame, pixel = 16*row + col
        vs_pulse();
        send_line(8'h00, 8'h01, 8, 8'h00, t0);
        send_line(8'h10, 8'h01, 8, 8'h10, t1);
        send_line(8'h20, 8'h01, 8, 8'h20, t2);
`ifdef MATRIX_REPLICATE_EN
        chk_win("ramp_r1c1", t1 + 3, {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd16, 8'd16, 8'd17});
`else
        chk_win("ramp_r1c1", t1 + 3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd16, 8'd17});
`endif
        chk_win("ramp_r2c3", t2 + 5, {8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35});

        // New frame: stale ramp data in the RAMs must stay hidden
        vs_pulse();
        send_line(8'hAA, 8'h00, 8, 8'h55, ta);
`ifdef MATRIX_REPLICATE_EN
        chk_win("border_r0c0", ta + 2, {9{8'h55}});
        chk_win("restart_r0c4", ta + 6, {9{8'hAA}});
`else
        chk_win("border_r0c0", ta + 2, {64'h0, 8'h55});
        chk_win("restart_r0c4", ta + 6, {48'h0, 8'hAA, 8'hAA, 8'hAA});
`endif
        send_line(8'hB0, 8'h01, 8, 8'hB0, tb);
`ifdef MATRIX_REPLICATE_EN
        chk_win("restart_r1c3", tb + 5, {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hB1, 8'hB2, 8'hB3});
`else
        chk_win("restart_r1c3", tb + 5, {24'h0, 8'hAA, 8'hAA, 8'hAA, 8'hB1, 8'hB2, 8'hB3});
`endif

        // Overlong line of 10 pixels, then a normal line reading it back
        send_line(8'hC0, 8'h01, 10, 8'hC0, tc);
        chk_win("long_c2", tc + 4, {8'h55, 8'hAA, 8'hAA, 8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1, 8'hC2});
        chk_win("long_c8", tc + 10, {8'hAA, 8'hAA, 8'h00, 8'hB6, 8'hB7, 8'h00, 8'hC6, 8'hC7, 8'hC8});
        chk_win("long_c9", tc + 11, {8'hAA, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h00, 8'hC7, 8'hC8, 8'hC9});
        send_line(8'hD0, 8'h01, 8, 8'hD0, td);
`ifdef MATRIX_REPLICATE_EN
        chk_win("after_long_c0", td + 2, {8'hB0, 8'hB0, 8'hB0, 8'hC0, 8'hC0, 8'hC0, 8'hD0, 8'hD0, 8'hD0});
`else
        chk_win("after_long_c0", td + 2, {8'h00, 8'h00, 8'hB0, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hD0});
`endif
        chk_win("after_long_c7", td + 9, {8'hB5, 8'hB6, 8'hB7, 8'hC5, 8'hC6, 8'hC7, 8'hD5, 8'hD6, 8'hD7});

        // Reset for three cycles in the middle of a streaming line
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        te = cyc;
        for (int j = 0; j < 8; j++) begin
            chk_sync = !(j >= 3 && j <= 6);
            tick((j >= 2 && j <= 4), 1'b0, 1'b0, 1'b1, 8'hE0 + 8'(j));
        end
        chk_sync = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int s = te + 3; s <= te + 6; s++) begin
            chk_win("midline_reset_taps", s, 72'h0);
            checks++;
            assert (ssync[s] === 3'b000) else begin
                errors++;
                $error("FAIL midline_reset_sync idx=%0d observed=%b expected=000", s, ssync[s]);
            end
        end
`ifdef MATRIX_REPLICATE_EN
        chk_win("post_reset_c0", te + 7, {9{8'hE5}});
        chk_win("post_reset_c2", te + 9, {3{8'hE5, 8'hE6, 8'hE7}});
`else
        chk_win("post_reset_c0", te + 7, {64'h0, 8'hE5});
        chk_win("post_reset_c2", te + 9, {48'h0, 8'hE5, 8'hE6, 8'hE7});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
